fifo_drain_checker: RTL and testbench

Read-side traffic engine for the FIFO test harness. It drains `top_FIFO` through its `read`/`dout`/`empty` interface, honours the FIFO's one-cycle read latency, and checks every popped word against an incrementing reference sequence. It reports word count, error count and first-mismatch data as level outputs, so the VIO can probe them as inputs. The VIO, or a pattern writer, fills the FIFO from the other side.

---
 rtl/fifo_test_pkg.sv | 16 +
 rtl/fifo_seq_checker.sv | 76 +++++++
 rtl/fifo_drain_checker.sv | 130 +++++++++++++
 tb/tb_fifo_drain_checker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_test_pkg.sv
// Shared definitions for the FIFO test harness: drain-checker FSM states and
// the default data/count widths also used by the pattern writer.
package fifo_test_pkg;

  // Default FIFO word width and counter width.
  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  // Drain-checker run states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_seq_checker.sv
// Compares each valid FIFO word with an incrementing reference sequence and
// keeps the run statistics: word count, saturating error count, sticky error
// flag and the expected/received pair of the first mismatch.
module fifo_seq_checker
  import fifo_test_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  input  logic [DATA_W-1:0] seed,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              err,
  output logic [DATA_W-1:0] first_exp,
  output logic [DATA_W-1:0] first_got
);

  logic [DATA_W-1:0] expected_reg;
  logic [CNT_W-1:0]  word_count_reg;
  logic [CNT_W-1:0]  err_count_reg;
  logic              err_reg;
  logic [DATA_W-1:0] first_exp_reg;
  logic [DATA_W-1:0] first_got_reg;

  logic mismatch;
  logic err_count_full;

  assign mismatch       = valid && (data != expected_reg);
  assign err_count_full = &err_count_reg;

  // Load the seed at run start, otherwise check and advance on every valid word.
  always_ff @(posedge clk) begin
    if (reset) begin
      expected_reg   <= '0;
      word_count_reg <= '0;
      err_count_reg  <= '0;
      err_reg        <= 1'b0;
      first_exp_reg  <= '0;
      first_got_reg  <= '0;
    end else if (load) begin
      expected_reg   <= seed;
      word_count_reg <= '0;
      err_count_reg  <= '0;
      err_reg        <= 1'b0;
      first_exp_reg  <= '0;
      first_got_reg  <= '0;
    end else if (valid) begin
      // The reference never resyncs to received data; it just counts on.
      expected_reg   <= expected_reg + DATA_W'(1);
      word_count_reg <= word_count_reg + CNT_W'(1);
      if (mismatch) begin
        if (!err_count_full) begin
          err_count_reg <= err_count_reg + CNT_W'(1);
        end
        err_reg <= 1'b1;
        // Only the first mismatch of a run is captured.
        if (!err_reg) begin
          first_exp_reg <= expected_reg;
          first_got_reg <= data;
        end
      end
    end
  end

  assign word_count = word_count_reg;
  assign err_count  = err_count_reg;
  assign err        = err_reg;
  assign first_exp  = first_exp_reg;
  assign first_got  = first_got_reg;

endmodule

// File: rtl/fifo_drain_checker.sv
// Read-side traffic engine: drains the FIFO, tracks its read latency with a
// valid pipe, and feeds popped words to the sequence checker.
module fifo_drain_checker
  import fifo_test_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] seed,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              empty,
  input  logic              almost_empty,
  input  logic [DATA_W-1:0] dout,
  output logic              read,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              err,
  output logic [DATA_W-1:0] first_exp,
  output logic [DATA_W-1:0] first_got
);

  state_t            state_reg;
  logic              start_q;
  logic              read_q;
  logic              done_reg;
  logic [CNT_W-1:0]  issued_reg;
  logic [RD_LAT-1:0] vpipe_reg;

  logic start_rise;
  logic limit;
  logic read_en;
  logic pipe_busy;
  logic check_valid;
  logic load;

  assign start_rise = start && !start_q;
  assign limit      = (burst_len != '0) && (issued_reg == burst_len);

  // After a pop the FIFO flags lag by a cycle, so when only one word may be
  // left we skip the cycle right after a pop instead of risking underflow.
  assign read_en = (state_reg == DRAIN) && !empty && !(read_q && almost_empty) && !limit;

  assign pipe_busy   = |vpipe_reg;
  assign check_valid = vpipe_reg[RD_LAT-1];
  assign load        = (state_reg == IDLE) && start_rise;

  // Valid pipe: marks the cycle in which each popped word appears on dout.
  always_ff @(posedge clk) begin
    if (reset) begin
      vpipe_reg <= '0;
    end else begin
      vpipe_reg[0] <= read_en;
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe_reg[i] <= vpipe_reg[i-1];
      end
    end
  end

  // Run control FSM with start edge detection, issued counter and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      start_q    <= 1'b0;
      read_q     <= 1'b0;
      done_reg   <= 1'b0;
      issued_reg <= '0;
    end else begin
      // The edge detector keeps tracking start in every state, so a level
      // held across a run never retriggers one.
      start_q  <= start;
      read_q   <= read_en;
      done_reg <= 1'b0;
      if (read_en) begin
        issued_reg <= issued_reg + CNT_W'(1);
      end
      case (state_reg)
        IDLE: begin
          if (start_rise) begin
            issued_reg <= '0;
            state_reg  <= DRAIN;
          end
        end
        DRAIN: begin
          if (stop || limit) begin
            state_reg <= FLUSH;
          end
        end
        FLUSH: begin
          // Let every outstanding read reach the checker before finishing.
          if (!pipe_busy) begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  fifo_seq_checker #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_seq_checker (
    .clk        (clk),
    .reset      (reset),
    .valid      (check_valid),
    .data       (dout),
    .load       (load),
    .seed       (seed),
    .word_count (word_count),
    .err_count  (err_count),
    .err        (err),
    .first_exp  (first_exp),
    .first_got  (first_got)
  );

  assign read = read_en;
  assign busy = (state_reg == DRAIN) || (state_reg == FLUSH);
  assign done = done_reg;

endmodule

// File: tb/tb_fifo_drain_checker.sv
// Directed bench for fifo_drain_checker with a behavioural FIFO model that
// has one-cycle registered read data.
module tb_fifo_drain_checker;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              stop;
  logic [DATA_W-1:0] seed;
  logic [CNT_W-1:0]  burst_len;
  logic              empty;
  logic              almost_empty;
  logic [DATA_W-1:0] dout = '0;
  logic              read;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  word_count;
  logic [CNT_W-1:0]  err_count;
  logic              err;
  logic [DATA_W-1:0] first_exp;
  logic [DATA_W-1:0] first_got;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fifo_drain_checker #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .seed         (seed),
    .burst_len    (burst_len),
    .empty        (empty),
    .almost_empty (almost_empty),
    .dout         (dout),
    .read         (read),
    .busy         (busy),
    .done         (done),
    .word_count   (word_count),
    .err_count    (err_count),
    .err          (err),
    .first_exp    (first_exp),
    .first_got    (first_got)
  );

  // Behavioural FIFO: writes from the stimulus, pops on read with registered dout.
  logic [DATA_W-1:0] mem [0:63];
  int   wr_ptr      = 0;
  int   rd_ptr      = 0;
  logic fifo_clr    = 1'b0;
  int   underflows  = 0;
  int   read_pulses = 0;
  int   done_pulses = 0;

  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    almost_empty = ((wr_ptr - rd_ptr) <= 1);
  end

  always @(posedge clk) begin
    if (read) read_pulses <= read_pulses + 1;
    if (done) done_pulses <= done_pulses + 1;
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (read) begin
      if (wr_ptr == rd_ptr) begin
        underflows <= underflows + 1;
      end else begin
        dout   <= mem[rd_ptr % 64];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    mem[wr_ptr % 64] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic begin_run(input logic [DATA_W-1:0] s, input logic [CNT_W-1:0] bl);
    seed      = s;
    burst_len = bl;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rd;
    int base_done;
    logic reached;

    reset     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    seed      = '0;
    burst_len = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_first_exp", 32'(first_exp), 32'd0);
    chk("rst_first_got", 32'(first_got), 32'd0);
    $display("reset: read=%0d busy=%0d word_count=%0d", read, busy, word_count);

    // Burst of 10 words 0..9
    for (int i = 0; i < 10; i++) push(4'(i));
    base_rd   = read_pulses;
    base_done = done_pulses;
    begin_run(4'h0, 8'd10);
    wait_done("burst_done_seen", 80);
    tick();
    tick();
    chk("burst_reads", 32'(read_pulses - base_rd), 32'd10);
    chk("burst_word_count", 32'(word_count), 32'd10);
    chk("burst_err_count", 32'(err_count), 32'd0);
    chk("burst_done_pulses", 32'(done_pulses - base_done), 32'd1);
    chk("burst_fifo_empty", 32'(empty), 32'd1);
    chk("burst_busy", 32'(busy), 32'd0);
    $display("burst10: reads=%0d word_count=%0d err_count=%0d", read_pulses - base_rd, word_count, err_count);

    // Wrap-around, unlimited length, ended by stop
    for (int i = 0; i < 18; i++) push(4'((14 + i) % 16));
    begin_run(4'hE, 8'd0);
    reached = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (empty) begin
        reached = 1'b1;
        break;
      end
    end
    chk("wrap_fifo_drained", 32'(reached), 32'd1);
    tick();
    tick();
    tick();
    chk("wrap_busy_before_stop", 32'(busy), 32'd1);
    stop = 1'b1;
    wait_done("wrap_done_seen", 20);
    stop = 1'b0;
    tick();
    chk("wrap_word_count", 32'(word_count), 32'd18);
    chk("wrap_err", 32'(err), 32'd0);
    chk("wrap_err_count", 32'(err_count), 32'd0);
    $display("wrap18: word_count=%0d err=%0d", word_count, err);

    // One corrupted word: 0,1,2,7,4
    push(4'h0); push(4'h1); push(4'h2); push(4'h7); push(4'h4);
    begin_run(4'h0, 8'd5);
    wait_done("mis_done_seen", 40);
    tick();
    chk("mis_err_count", 32'(err_count), 32'd1);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_first_exp", 32'(first_exp), 32'd3);
    chk("mis_first_got", 32'(first_got), 32'd7);
    chk("mis_word_count", 32'(word_count), 32'd5);
    $display("mismatch: err_count=%0d first_exp=%0h first_got=%0h", err_count, first_exp, first_got);

    // Single word with almost_empty high, then a late second word
    push(4'h0);
    base_rd = read_pulses;
    begin_run(4'h0, 8'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("single_reads", 32'(read_pulses - base_rd), 32'd1);
    chk("single_read_low", 32'(read), 32'd0);
    chk("single_word_count", 32'(word_count), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_underflow", 32'(underflows), 32'd0);
    push(4'h1);
    for (int i = 0; i < 6; i++) tick();
    chk("single_resume_reads", 32'(read_pulses - base_rd), 32'd2);
    chk("single_resume_word_count", 32'(word_count), 32'd2);
    chk("single_resume_err", 32'(err), 32'd0);
    stop = 1'b1;
    wait_done("single_done_seen", 20);
    stop = 1'b0;
    tick();
    $display("single: reads=%0d underflows=%0d", read_pulses - base_rd, underflows);

    // Reset three words into a 10-word burst
    for (int i = 0; i < 10; i++) push(4'(i));
    begin_run(4'h0, 8'd10);
    reached = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (word_count == 8'd3) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    chk("rstrun_reached_3", 32'(reached), 32'd1);
    base_done = done_pulses;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstrun_read", 32'(read), 32'd0);
    chk("rstrun_busy", 32'(busy), 32'd0);
    chk("rstrun_word_count", 32'(word_count), 32'd0);
    chk("rstrun_err_count", 32'(err_count), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("rstrun_no_done", 32'(done_pulses - base_done), 32'd0);
    chk("rstrun_idle_read", 32'(read), 32'd0);
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
    tick();
    $display("reset_mid_run: busy=%0d word_count=%0d", busy, word_count);

    // Start held high with an extra edge while busy
    for (int i = 0; i < 5; i++) push(4'(i));
    base_rd   = read_pulses;
    base_done = done_pulses;
    seed      = 4'h0;
    burst_len = 8'd5;
    start     = 1'b1;
    tick();
    chk("hold_busy", 32'(busy), 32'd1);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    wait_done("hold_done_seen", 40);
    for (int i = 0; i < 10; i++) tick();
    chk("hold_done_pulses", 32'(done_pulses - base_done), 32'd1);
    chk("hold_reads", 32'(read_pulses - base_rd), 32'd5);
    chk("hold_word_count", 32'(word_count), 32'd5);
    chk("hold_err", 32'(err), 32'd0);
    chk("hold_idle", 32'(busy), 32'd0);
    start = 1'b0;
    tick();
    $display("start_hold: done_pulses=%0d reads=%0d", done_pulses - base_done, read_pulses - base_rd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
